// File: rtl/isa_encoder_if.sv
// isa_encoder_if: command, instruction-stream and status signals of the
// CGRA lane instruction encoder, bundled so host and lane hook up in one go.
//   cmd_*          field-level command from the control sequencer (valid/ready)
//   m_instr_*      packed 32-bit instruction stream toward the lane decode
//   err_illegal    one-cycle pulse for an accepted unsupported op
//   fifo_count     instruction buffer occupancy
// Modports: master = encoder side, slave = host/consumer side.
interface isa_encoder_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [4:0]       cmd_rd;
    logic [4:0]       cmd_rs1;
    logic [4:0]       cmd_rs2;
    logic [2:0]       cmd_csel;
    logic [31:0]      cmd_imm;
    logic [31:0]      m_instr_tdata;
    logic             m_instr_tvalid;
    logic             m_instr_tready;
    logic             err_illegal;
    logic [CNT_W-1:0] fifo_count;

    modport master (
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_csel, cmd_imm,
        input  m_instr_tready,
        output cmd_ready, m_instr_tdata, m_instr_tvalid, err_illegal, fifo_count
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, cmd_csel, cmd_imm,
        output m_instr_tready,
        input  cmd_ready, m_instr_tdata, m_instr_tvalid, err_illegal, fifo_count
    );
endinterface

// File: rtl/isa_encoder.sv
// isa_encoder: packs field-level commands into 32-bit lane instructions and
// buffers them in a FIFO drained over a valid/ready stream.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   bus        isa_encoder_if.master (command in, instruction stream out,
//              err_illegal pulse, fifo_count occupancy)
// Parameters:
//   FIFO_DEPTH power of two, >= 2
//   CSR_ID     value placed in [31:20] of CSR words
// Build option: define ISA_ENC_LI_EN to enable the two-word LI expansion
// (op 9 -> LUI + ADDI); otherwise op 9 is treated as illegal.
module isa_encoder #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [11:0] CSR_ID     = 12'hC00
) (
    input  logic          clk,
    input  logic          rst,
    isa_encoder_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [3:0] OP_VMACC    = 4'd0;
    localparam logic [3:0] OP_VLE32    = 4'd1;
    localparam logic [3:0] OP_VSE32    = 4'd2;
    localparam logic [3:0] OP_VMV_VI   = 4'd3;
    localparam logic [3:0] OP_VSETIVLI = 4'd4;
    localparam logic [3:0] OP_BEQ      = 4'd5;
    localparam logic [3:0] OP_ADDI     = 4'd6;
    localparam logic [3:0] OP_LUI      = 4'd7;
    localparam logic [3:0] OP_CSR      = 4'd8;
`ifdef ISA_ENC_LI_EN
    localparam logic [3:0] OP_LI       = 4'd9;
`endif

`ifdef ISA_ENC_LI_EN
    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LI2  = 1'b1
    } state_t;
`else
    typedef enum logic [0:0] {
        S_IDLE = 1'b0
    } state_t;
`endif

    state_t           r_state;
    state_t           w_state_nxt;

    logic [31:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_cmd_ready;
    logic             r_tvalid;
    logic [31:0]      r_tdata;
    logic             r_err;

    logic             w_accept;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic [31:0]      w_push_data;
    logic             w_illegal;
    logic             w_legal;
    logic [31:0]      w_dec_word;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] w_rd_ptr_nxt;
    logic [31:0]      w_head_nxt;

`ifdef ISA_ENC_LI_EN
    logic [31:0]      r_li2_word;
    logic [31:0]      w_li2_nxt;
    logic [31:0]      w_li_addi;
    logic [19:0]      w_li_upper;
    logic             w_li_op;
`endif

    assign w_full   = (r_count == FULL_CNT);
    assign w_accept = bus.cmd_valid && r_cmd_ready;
    assign w_pop    = r_tvalid && bus.m_instr_tready;

    // Field packing for the currently presented command
    always_comb begin
        w_legal    = 1'b1;
        w_dec_word = '0;
`ifdef ISA_ENC_LI_EN
        w_li_op    = 1'b0;
        // Pre-compensate the upper half for the sign-extended ADDI immediate
        w_li_upper = bus.cmd_imm[31:12] + 20'(bus.cmd_imm[11]);
        w_li_addi  = {bus.cmd_imm[11:0], bus.cmd_rd, 3'd0, bus.cmd_rd, 7'h13};
`endif
        case (bus.cmd_op)
            OP_VMACC:    w_dec_word = {7'd0, bus.cmd_rs2, 2'd0, bus.cmd_csel, 3'd0,
                                       bus.cmd_rd, 7'h57};
            OP_VLE32:    w_dec_word = {14'd0, bus.cmd_csel, 3'd0, bus.cmd_rd, 7'h07};
            OP_VSE32:    w_dec_word = {14'd0, bus.cmd_csel, 3'd0, bus.cmd_rd, 7'h27};
            OP_VMV_VI:   w_dec_word = {7'd0, bus.cmd_rs2, 2'd0, bus.cmd_csel, 3'd5,
                                       bus.cmd_rd, 7'h57};
            OP_VSETIVLI: w_dec_word = {2'd0, bus.cmd_imm[11:0], 3'd0, 3'd7, 5'd0, 7'h57};
            // B-type immediate scatter
            OP_BEQ:      w_dec_word = {bus.cmd_imm[11], bus.cmd_imm[9:4], bus.cmd_rs2,
                                       bus.cmd_rs1, 3'd0, bus.cmd_imm[3:0],
                                       bus.cmd_imm[10], 7'h63};
            OP_ADDI:     w_dec_word = {bus.cmd_imm[11:0], bus.cmd_rs1, 3'd0,
                                       bus.cmd_rd, 7'h13};
            OP_LUI:      w_dec_word = {bus.cmd_imm[31:12], bus.cmd_rd, 7'h37};
            OP_CSR:      w_dec_word = {CSR_ID, 5'd0, 3'd0, bus.cmd_rd, 7'h03};
`ifdef ISA_ENC_LI_EN
            OP_LI: begin
                w_dec_word = {w_li_upper, bus.cmd_rd, 7'h37};
                w_li_op    = 1'b1;
            end
`endif
            default:     w_legal = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and FIFO write request
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = w_dec_word;
        w_illegal   = 1'b0;
`ifdef ISA_ENC_LI_EN
        w_li2_nxt   = r_li2_word;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal) begin
                        w_illegal = 1'b1;
                    end else begin
                        w_push = 1'b1;
`ifdef ISA_ENC_LI_EN
                        if (w_li_op) begin
                            w_state_nxt = S_LI2;
                            w_li2_nxt   = w_li_addi;
                        end
`endif
                    end
                end
            end
`ifdef ISA_ENC_LI_EN
            // Second LI word waits here until a slot frees up
            S_LI2: begin
                if (!w_full) begin
                    w_push      = 1'b1;
                    w_push_data = r_li2_word;
                    w_state_nxt = S_IDLE;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

`ifdef ISA_ENC_LI_EN
    // Held ADDI half of an LI expansion
    always_ff @(posedge clk) begin
        if (rst) begin
            r_li2_word <= '0;
        end else begin
            r_li2_word <= w_li2_nxt;
        end
    end
`endif

    assign w_count_nxt  = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;

    // The only way a write lands on the next head is when the FIFO is empty
    // after this cycle's pop, so forward the incoming word in that case.
    always_comb begin
        w_head_nxt = r_mem[w_rd_ptr_nxt];
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
            w_head_nxt = w_push_data;
        end
    end

    // Storage array, no reset needed
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    // Pointers, occupancy and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
            r_tvalid    <= 1'b0;
            r_tdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr    <= w_rd_ptr_nxt;
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_state_nxt == S_IDLE) && (w_count_nxt != FULL_CNT);
            r_tvalid    <= (w_count_nxt != '0);
            r_tdata     <= w_head_nxt;
            r_err       <= w_illegal;
        end
    end

    assign bus.cmd_ready      = r_cmd_ready;
    assign bus.m_instr_tvalid = r_tvalid;
    assign bus.m_instr_tdata  = r_tdata;
    assign bus.err_illegal    = r_err;
    assign bus.fifo_count     = r_count;

endmodule

// File: tb/tb_isa_encoder.sv
// tb_isa_encoder: drives directed and random commands into isa_encoder,
// predicts instruction words with an arithmetic model of the encodings and
// checks the stream through a queue-based monitor.
module tb_isa_encoder;
    localparam int unsigned DEPTH  = 8;
    localparam logic [11:0] CSR_ID = 12'hC00;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    isa_encoder_if #(.FIFO_DEPTH(DEPTH)) bus ();

    isa_encoder #(.FIFO_DEPTH(DEPTH), .CSR_ID(CSR_ID)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int edges = 0;
    int ready_mode = 1;
    logic [31:0] exp_q[$];
    int          err_q[$];

    always @(posedge clk) edges <= edges + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference encodings built from plain arithmetic on the field values
    function automatic void model(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2, input logic [2:0] csel, input logic [31:0] imm,
                                  output int n, output logic [31:0] w0, output logic [31:0] w1);
        int unsigned d, s1, s2, c, im, lo12, up;
        d = rd; s1 = rs1; s2 = rs2; c = csel; im = imm; lo12 = im % 4096;
        n = 1; w0 = '0; w1 = '0; up = 0;
        case (op)
            4'd0: w0 = s2 * 1048576 + c * 32768 + d * 128 + 'h57;
            4'd1: w0 = c * 32768 + d * 128 + 'h07;
            4'd2: w0 = c * 32768 + d * 128 + 'h27;
            4'd3: w0 = s2 * 1048576 + c * 32768 + 5 * 4096 + d * 128 + 'h57;
            4'd4: w0 = lo12 * 262144 + 7 * 4096 + 'h57;
            4'd5: w0 = ((lo12 / 2048) % 2) * 32'h8000_0000 + ((lo12 / 16) % 64) * 33554432
                       + s2 * 1048576 + s1 * 32768 + (lo12 % 16) * 256
                       + ((lo12 / 1024) % 2) * 128 + 'h63;
            4'd6: w0 = lo12 * 1048576 + s1 * 32768 + d * 128 + 'h13;
            4'd7: w0 = (im / 4096) * 4096 + d * 128 + 'h37;
            4'd8: w0 = 32'(CSR_ID) * 1048576 + d * 128 + 'h03;
`ifdef ISA_ENC_LI_EN
            4'd9: begin
                n  = 2;
                up = ((im / 4096) + ((im / 2048) % 2)) % 1048576;
                w0 = up * 4096 + d * 128 + 'h37;
                w1 = lo12 * 1048576 + d * 32768 + d * 128 + 'h13;
            end
`endif
            default: n = 0;
        endcase
    endfunction

    // Consumer ready pattern: 0 random, 1 always ready, other stalled
    initial begin
        bus.m_instr_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.m_instr_tready = ($urandom_range(0, 2) != 0);
                1:       bus.m_instr_tready = 1'b1;
                default: bus.m_instr_tready = 1'b0;
            endcase
        end
    end

    // Monitor: stream ordering, stall stability, err_illegal pulses
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    always @(negedge clk) begin
        logic exp_e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", 32'(bus.m_instr_tvalid), 32'd1);
                check("hold_data", bus.m_instr_tdata, prev_data);
            end
            if (bus.m_instr_tvalid && bus.m_instr_tready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got %h want none", bus.m_instr_tdata);
                end else begin
                    check("word", bus.m_instr_tdata, exp_q.pop_front());
                end
            end
            prev_stall = bus.m_instr_tvalid && !bus.m_instr_tready;
            prev_data  = bus.m_instr_tdata;
            exp_e = (err_q.size() > 0) && (err_q[0] == edges);
            if (exp_e) void'(err_q.pop_front());
            if (exp_e || bus.err_illegal) check("err_illegal", 32'(bus.err_illegal), 32'(exp_e));
        end
    end

    // Present one command and wait for it to be taken; returns at posedge+1
    task automatic send(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] csel, input logic [31:0] imm,
                        output int acc_edge);
        int   waited;
        logic rdy;
        logic done;
        waited = 0; done = 1'b0; acc_edge = -1;
        @(posedge clk);
        #1;
        bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        bus.cmd_csel = csel; bus.cmd_imm = imm; bus.cmd_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            rdy = bus.cmd_ready;
            @(posedge clk);
            if (rdy) begin
                acc_edge = edges + 1;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 200) begin
                    total++;
                    bad++;
                    $display("FAIL send_timeout: op %0d not accepted after %0d cycles", op, waited);
                    done = 1'b1;
                end
            end
        end
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] op);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  csel;
        logic [31:0] imm, w0, w1;
        int e, n;
        rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        csel = 3'($urandom); imm = $urandom;
        send(op, rd, rs1, rs2, csel, imm, e);
        if (e >= 0) begin
            model(op, rd, rs1, rs2, csel, imm, n, w0, w1);
            if (n == 0) err_q.push_back(e);
            else begin
                exp_q.push_back(w0);
                if (n == 2) exp_q.push_back(w1);
            end
        end
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || bus.m_instr_tvalid) && k < 500) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_tready(input logic v);
        int k;
        k = 0;
        @(negedge clk);
        while (bus.m_instr_tready !== v && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("tready_settle", 32'(bus.m_instr_tready), 32'(v));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0;
        bus.cmd_rs2 = '0; bus.cmd_csel = '0; bus.cmd_imm = '0;
        ready_mode = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("rst_tvalid", 32'(bus.m_instr_tvalid), 32'd0);
        check("rst_tdata", bus.m_instr_tdata, 32'd0);
        check("rst_err", 32'(bus.err_illegal), 32'd0);
        check("rst_count", 32'(bus.fifo_count), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("ready_before_edge", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);

        // VMACC latency and word
        send(4'd0, 5'd3, 5'd0, 5'd5, 3'd2, 32'd0, e);
        exp_q.push_back(32'h005101D7);
        @(negedge clk);
        check("vmacc_valid", 32'(bus.m_instr_tvalid), 32'd1);
        check("vmacc_data", bus.m_instr_tdata, 32'h005101D7);

        // ADDI then BEQ, VSETIVLI then CSR
        send(4'd6, 5'd1, 5'd1, 5'd0, 3'd0, 32'hFFFF_FFFC, e);
        exp_q.push_back(32'hFFC08093);
        send(4'd5, 5'd0, 5'd4, 5'd6, 3'd0, 32'h0000_0805, e);
        exp_q.push_back(32'h80620563);
        send(4'd4, 5'd0, 5'd0, 5'd0, 3'd0, 32'h0000_0040, e);
        exp_q.push_back(32'h01007057);
        send(4'd8, 5'd5, 5'd0, 5'd0, 3'd0, 32'd0, e);
        exp_q.push_back(32'hC0000283);
        drain("drain_directed");

        // LI
`ifdef ISA_ENC_LI_EN
        send(4'd9, 5'd2, 5'd0, 5'd0, 3'd0, 32'h12345FFF, e);
        exp_q.push_back(32'h12346137);
        exp_q.push_back(32'hFFF10113);
        @(negedge clk);
        check("li_ready_low", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("li_ready_back", 32'(bus.cmd_ready), 32'd1);
`else
        send(4'd9, 5'd2, 5'd0, 5'd0, 3'd0, 32'h12345FFF, e);
        err_q.push_back(e);
        @(negedge clk);
        check("li_ill_count", 32'(bus.fifo_count), 32'd0);
        @(negedge clk);
        check("li_ill_count2", 32'(bus.fifo_count), 32'd0);
`endif
        drain("drain_li");
        send(4'd15, 5'd7, 5'd7, 5'd7, 3'd7, 32'hFFFF_FFFF, e);
        err_q.push_back(e);
        @(negedge clk);
        check("op15_count", 32'(bus.fifo_count), 32'd0);
        check("op15_valid", 32'(bus.m_instr_tvalid), 32'd0);

        // Fill to full with the consumer stalled, then drain
        ready_mode = 2;
        wait_tready(1'b0);
        for (int i = 0; i < int'(DEPTH); i++) issue(4'($urandom_range(0, 8)));
        @(negedge clk);
        check("full_count", 32'(bus.fifo_count), 32'(DEPTH));
        check("full_ready", 32'(bus.cmd_ready), 32'd0);
        check("full_valid", 32'(bus.m_instr_tvalid), 32'd1);
        repeat (3) @(negedge clk);
        check("full_ready_hold", 32'(bus.cmd_ready), 32'd0);
        ready_mode = 1;
        wait_tready(1'b1);
        check("full_pop_count", 32'(bus.fifo_count), 32'(DEPTH));
        check("full_pop_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check("after_pop_count", 32'(bus.fifo_count), 32'(DEPTH - 1));
        check("after_pop_ready", 32'(bus.cmd_ready), 32'd1);
        drain("drain_full");
        check("drained_ready", 32'(bus.cmd_ready), 32'd1);
        check("drained_count", 32'(bus.fifo_count), 32'd0);

`ifdef ISA_ENC_LI_EN
        // Reset while the ADDI half is pending
        ready_mode = 2;
        wait_tready(1'b0);
        send(4'd9, 5'd9, 5'd0, 5'd0, 3'd0, 32'hABCDE800, e);
        rst = 1'b1;
        exp_q.delete();
        err_q.delete();
        @(negedge clk);
        check("li2_rst_count", 32'(bus.fifo_count), 32'd0);
        check("li2_rst_valid", 32'(bus.m_instr_tvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 1;
        repeat (4) @(negedge clk);
        check("li2_post_valid", 32'(bus.m_instr_tvalid), 32'd0);
        check("li2_post_ready", 32'(bus.cmd_ready), 32'd1);
`endif

        // Random traffic with random backpressure
        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            issue(4'($urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end
        ready_mode = 1;
        drain("drain_random");
        repeat (2) @(negedge clk);
        check("err_q_empty", 32'(err_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/isa_encoder.md
# isa_encoder

Instruction-stream generator for the CGRA vector lane. It accepts field-level commands from the host/control sequencer, packs them into the 32-bit instruction words the lane's decode stage consumes, and buffers them in a small FIFO. The FIFO drains over an AXI-Stream-style valid/ready port into the lane's instruction input.

## Interface
- `FIFO_DEPTH`, default 8: instruction buffer entries; must be a power of 2 and at least 2.
- `CSR_ID`, default 12'hC00: value placed in bits [31:20] of CSR reads.
- `clk`  in  1  clock. Every flop is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  command accepted on a cycle where `cmd_valid && cmd_ready`.
- `cmd_op`  in  4  operation select (see Operation).
- `cmd_rd`  in  5  destination register: vd or rd.
- `cmd_rs1`  in  5  scalar source 1.
- `cmd_rs2`  in  5  source 2: vs2 or rs2.
- `cmd_csel`  in  3  chunk-size select, written to bits [17:15].
- `cmd_imm`  in  32  immediate. The low bits are used per op.
- `m_instr_tdata`  out  32  encoded instruction.
- `m_instr_tvalid`  out  1  word available.
- `m_instr_tready`  in  1  consumer accepts the word.
- `err_illegal`  out  1  one-cycle pulse when an unsupported `cmd_op` is accepted.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
Encodings per `cmd_op`. All bits not listed are 0.
- 0 VMACC: {vs2 at [24:20], csel at [17:15], funct3=0, vd at [11:7], opcode 7'h57}.
- 1 VLE32: {csel at [17:15], vd at [11:7], opcode 7'h07}.
- 2 VSE32: {csel at [17:15], vd at [11:7], opcode 7'h27}.
- 3 VMV_VI: {vs2 at [24:20], csel at [17:15], funct3=5, vd at [11:7], opcode 7'h57}.
- 4 VSETIVLI: {imm[11:0] at [29:18], funct3=7, opcode 7'h57}.
- 5 BEQ: imm[11] at bit 31, imm[10] at bit 7, imm[9:4] at [30:25], imm[3:0] at [11:8]; rs2 at [24:20]; rs1 at [19:15]; funct3=0; opcode 7'h63.
- 6 ADDI: {imm[11:0] at [31:20], rs1 at [19:15], funct3=0, rd at [11:7], opcode 7'h13}.
- 7 LUI: {imm[31:12] at [31:12], rd at [11:7], opcode 7'h37}.
- 8 CSR: {CSR_ID at [31:20], rd at [11:7], opcode 7'h03}.
- 9 LI: two-word expansion. Exists only when the LI macro is defined; see Configuration.
- 10–15 are illegal. They are accepted and dropped, `err_illegal` pulses, and nothing is pushed to the FIFO.

FIFO behaviour:
- Push and pop may happen in the same cycle. Occupancy is then unchanged.
- Output words leave in order of arrival.
- Pointers wrap modulo `FIFO_DEPTH`.

FSM states:
- S_IDLE: `cmd_ready = !full`. Accepting a single-word op pushes one word and the FSM stays in S_IDLE.
- S_LI2 (LI only): `cmd_ready = 0`. Pushes the ADDI half as soon as `!full`, then returns to S_IDLE. If the FIFO is full it waits, holding the word.

`cmd_ready` never depends combinationally on `m_instr_tready`.

## Timing
- Reset values:
  - `cmd_ready` = 0 during reset and 1 in the first cycle after reset deasserts.
  - `m_instr_tvalid` = 0, `m_instr_tdata` = 0, `err_illegal` = 0, `fifo_count` = 0.
  - FSM = S_IDLE.
- Latency: a command accepted at edge N into an empty FIFO drives `m_instr_tvalid` = 1 with its word after edge N (1 cycle).
- Stream rules:
  - `m_instr_tdata` is held stable while `tvalid && !tready`.
  - `tvalid` deasserts only after the last word is popped.
- Full FIFO: `cmd_ready` = 0 until at least one pop.
- Full FIFO with a pop in the same cycle: `cmd_ready` still reads 0 that cycle, because there is no bypass.
- `err_illegal` is registered. It is high for exactly the cycle after acceptance.
- Reset in S_LI2 clears the FIFO and the FSM. The ADDI half is discarded.

## Configuration
- `ISA_ENC_LI_EN` defined:
  - op 9 (LI) emits LUI rd with upper = imm[31:12] + imm[11] (mod 2^20).
  - It then emits ADDI rd, rd, imm[11:0] via S_LI2.
  - The two words are consecutive in the FIFO.
- `ISA_ENC_LI_EN` undefined:
  - S_LI2 is not built.
  - op 9 is illegal: `err_illegal` pulses and no word is pushed.

## Test plan
- VMACC with rd=3, rs2=5, csel=2, `tready`=1: `m_instr_tdata` = 32'h005101D7, with `tvalid` asserted 1 cycle after acceptance.
- ADDI with rd=1, rs1=1, imm=-4, then BEQ with rs1=4, rs2=6, imm=12'h805: words 32'hFFC08093 then 32'h80620563, in order.
- VSETIVLI with imm=12'h040, then CSR with rd=5: words 32'h01007057 then 32'hC0000283.
- LI (`ISA_ENC_LI_EN` defined) with rd=2, imm=32'h12345FFF: 32'h12346137 then 32'hFFF10113; `cmd_ready` = 0 for one cycle.
- LI without the macro: `err_illegal` = 1 for one cycle and `fifo_count` stays 0. With the macro, `cmd_op`=15 gives the same response.
- Hold `tready`=0 and send 8 commands: `fifo_count`=8 and `cmd_ready`=0. Raise `tready`: 8 words drain in order and `cmd_ready` returns to 1. Then, with the macro defined, assert `rst` in S_LI2: `fifo_count`=0 and `tvalid`=0 on the next cycle.
